// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC_F, issues imem requests, loads the IF/ID register and
// redirects fetch for branches/jumps after one delay slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Br,
    input  logic [15:0] Imm16,
    input  logic        JType,
    input  logic [25:0] JTarget,
    input  logic        JrType,
    input  logic [31:0] JrAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] IR_D,
    output logic [31:0] PC4_D,
    output logic        Valid_D
);

    typedef enum logic {FETCH = 1'b0, FULL = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] PC_F;
    logic [31:0] buf_ir;
    logic        redir_pend;
    logic [31:0] redir_pc;

    logic        redir, br_leave, load, bubble, capture;
    logic [31:0] target, next_pc, load_ir, pc_f4;

    assign pc_f4    = PC_F + 32'd4;
    assign redir    = Valid_D & (JrType | JType | Br);
    assign br_leave = redir & ~Stall;

    always_comb begin
        target = PC4_D + {{14{Imm16[15]}}, Imm16, 2'b00};
        if (JrType)     target = {JrAddr[31:2], 2'b00};
        else if (JType) target = {PC4_D[31:28], JTarget, 2'b00};
    end

    assign load    = ~Stall & ((state == FULL) | ((state == FETCH) & imem_ack));
    assign bubble  = ~Stall & (state == FETCH) & ~imem_ack;
    assign capture = Stall & (state == FETCH) & imem_ack;
    assign load_ir = (state == FULL) ? buf_ir : imem_rdata;

    always_comb begin
        next_pc = pc_f4;
        if (br_leave)        next_pc = target;
        else if (redir_pend) next_pc = redir_pc;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (imem_ack && Stall) state_nxt = FULL;
            FULL:  if (!Stall)            state_nxt = FETCH;
            default:                      state_nxt = FETCH;
        endcase
    end

    // Outputs; request is suppressed during reset so a late ack cannot be taken
    always_comb begin
        imem_req  = rst_n & (state == FETCH);
        imem_addr = PC_F;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC_F       <= RESET_PC;
            buf_ir     <= '0;
            redir_pend <= 1'b0;
            redir_pc   <= '0;
            IR_D       <= '0;
            PC4_D      <= '0;
            Valid_D    <= 1'b0;
        end else begin
            if (capture) buf_ir <= imem_rdata;
            if (load) begin
                IR_D    <= load_ir;
                PC4_D   <= pc_f4;
                Valid_D <= 1'b1;
                PC_F    <= next_pc;
            end else if (bubble) begin
                IR_D    <= '0;
                Valid_D <= 1'b0;
            end
            // Branch left ID before its delay slot arrived: remember where to go after it
            if (br_leave && !load) begin
                redir_pend <= 1'b1;
                redir_pc   <= target;
            end else if (load) begin
                redir_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected IF/ID loads plus
// per-cycle checks of the fetch address stream.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall = 1'b0, Br = 1'b0, JType = 1'b0, JrType = 1'b0;
    logic [15:0] Imm16 = '0;
    logic [25:0] JTarget = '0;
    logic [31:0] JrAddr = '0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata, IR_D, PC4_D;
    logic        Valid_D;

    int   n_tests = 0, n_fail = 0;
    exp_t sb[$];
    exp_t e;
    logic [31:0] ir_hold;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Br(Br), .Imm16(Imm16),
        .JType(JType), .JTarget(JTarget), .JrType(JrType), .JrAddr(JrAddr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .IR_D(IR_D), .PC4_D(PC4_D), .Valid_D(Valid_D)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] addr);
        exp_t x;
        x.ir  = mem_word(addr);
        x.pc4 = addr + 32'd4;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        {Stall, Br, JType, JrType, imem_ack} = '0;
        Imm16 = '0; JTarget = '0; JrAddr = '0;
        sb.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({imem_req, Valid_D, IR_D, PC4_D} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_state: req=%0b v=%0b ir=%h pc4=%h, want all 0", imem_req, Valid_D, IR_D, PC4_D);
        end
        do_reset();
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
            n_fail++;
            $display("FAIL reset_addr: req=%0b addr=%h, want 1 3000", imem_req, imem_addr);
        end
    endtask

    task automatic test_seq();
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (imem_addr !== 32'h3000 + 4 * i) begin
                n_fail++;
                $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, 32'h3000 + 4 * i);
            end
            push_exp(32'h3000 + 4 * i);
            tick();
            e = sb.pop_front();
            n_tests++;
            if ({Valid_D, IR_D, PC4_D} !== {1'b1, e.ir, e.pc4}) begin
                n_fail++;
                $display("FAIL seq_load%0d: v=%0b ir=%h pc4=%h want ir=%h pc4=%h", i, Valid_D, IR_D, PC4_D, e.ir, e.pc4);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        imem_ack = 1'b1;
        push_exp(32'h3000);
        tick();
        // Taken branch in ID during a stall must be ignored
        Br = 1'b1; Imm16 = 16'h0003; Stall = 1'b1; imem_ack = 1'b0;
        tick();
        Stall = 1'b0; imem_ack = 1'b1;
        #1;
        n_tests++;
        if (imem_addr !== 32'h3004) begin
            n_fail++;
            $display("FAIL br_stall_addr: got %h want 00003004", imem_addr);
        end
        push_exp(32'h3004);
        tick();
        Br = 1'b0;
        #1;
        n_tests++;
        if (imem_addr !== 32'h3010) begin
            n_fail++;
            $display("FAIL br_target: got %h want 00003010", imem_addr);
        end
        push_exp(32'h3010);
        tick();
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            n_tests++;
            if (i == 2 && {Valid_D, IR_D, PC4_D} !== {1'b1, e.ir, e.pc4}) begin
                n_fail++;
                $display("FAIL br_load: v=%0b ir=%h pc4=%h want ir=%h pc4=%h", Valid_D, IR_D, PC4_D, e.ir, e.pc4);
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        imem_ack = 1'b1;
        tick();
        JType = 1'b1; JTarget = 26'h0000C10;
        tick();
        JType = 1'b0;
        #1;
        n_tests++;
        if (imem_addr !== 32'h3040) begin
            n_fail++;
            $display("FAIL j_target: got %h want 00003040", imem_addr);
        end
        push_exp(32'h3040);
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({Valid_D, IR_D, PC4_D} !== {1'b1, e.ir, e.pc4}) begin
            n_fail++;
            $display("FAIL j_load: v=%0b ir=%h pc4=%h want ir=%h pc4=%h", Valid_D, IR_D, PC4_D, e.ir, e.pc4);
        end
        JrType = 1'b1; JrAddr = 32'h0000_3043;
        tick();
        JrType = 1'b0;
        #1;
        n_tests++;
        if (imem_addr !== 32'h3040 || PC4_D !== 32'h3048) begin
            n_fail++;
            $display("FAIL jr_target: addr=%h pc4=%h want 00003040 00003048", imem_addr, PC4_D);
        end
    endtask

    task automatic test_stall();
        do_reset();
        imem_ack = 1'b1;
        tick();
        ir_hold = IR_D;
        // Stall with no ack: IF/ID must hold, not bubble
        imem_ack = 1'b0; Stall = 1'b1;
        tick();
        n_tests++;
        if (Valid_D !== 1'b1 || IR_D !== ir_hold) begin
            n_fail++;
            $display("FAIL stall_noack_hold: v=%0b ir=%h want 1 %h", Valid_D, IR_D, ir_hold);
        end
        imem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (imem_req !== 1'b0 || IR_D !== ir_hold || PC4_D !== 32'h3004) begin
                n_fail++;
                $display("FAIL stall_full%0d: req=%0b ir=%h pc4=%h want 0 %h 00003004", i, imem_req, IR_D, PC4_D, ir_hold);
            end
        end
        Stall = 1'b0; imem_ack = 1'b0;
        push_exp(32'h3004);
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({Valid_D, IR_D, PC4_D} !== {1'b1, e.ir, e.pc4}) begin
            n_fail++;
            $display("FAIL stall_release: v=%0b ir=%h pc4=%h want ir=%h pc4=%h", Valid_D, IR_D, PC4_D, e.ir, e.pc4);
        end
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin
            n_fail++;
            $display("FAIL stall_next: req=%0b addr=%h want 1 00003008", imem_req, imem_addr);
        end
        imem_ack = 1'b1;
        push_exp(32'h3008);
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({Valid_D, IR_D, PC4_D} !== {1'b1, e.ir, e.pc4}) begin
            n_fail++;
            $display("FAIL stall_after: v=%0b ir=%h pc4=%h want ir=%h pc4=%h", Valid_D, IR_D, PC4_D, e.ir, e.pc4);
        end
    endtask

    task automatic test_wait_branch();
        do_reset();
        imem_ack = 1'b1;
        tick();
        Br = 1'b1; Imm16 = 16'h0003; imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (Valid_D !== 1'b0 || IR_D !== 32'd0 || imem_addr !== 32'h3004) begin
                n_fail++;
                $display("FAIL wait_bubble%0d: v=%0b ir=%h addr=%h want 0 0 00003004", i, Valid_D, IR_D, imem_addr);
            end
        end
        Br = 1'b0; imem_ack = 1'b1;
        push_exp(32'h3004);
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({Valid_D, IR_D, PC4_D} !== {1'b1, e.ir, e.pc4}) begin
            n_fail++;
            $display("FAIL wait_slot: v=%0b ir=%h pc4=%h want ir=%h pc4=%h", Valid_D, IR_D, PC4_D, e.ir, e.pc4);
        end
        n_tests++;
        if (imem_addr !== 32'h3010) begin
            n_fail++;
            $display("FAIL wait_target: got %h want 00003010", imem_addr);
        end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        imem_ack = 1'b1;
        tick();
        Br = 1'b1; Imm16 = 16'h0003; imem_ack = 1'b0;
        tick();
        Br = 1'b0;
        #2;
        rst_n = 1'b0;
        imem_ack = 1'b1;
        #1;
        n_tests++;
        if ({imem_req, Valid_D, IR_D, dut.redir_pend} !== 35'd0) begin
            n_fail++;
            $display("FAIL midwait_reset: req=%0b v=%0b ir=%h pend=%0b want all 0", imem_req, Valid_D, IR_D, dut.redir_pend);
        end
        tick();
        n_tests++;
        if (Valid_D !== 1'b0 || IR_D !== 32'd0) begin
            n_fail++;
            $display("FAIL midwait_lateack: v=%0b ir=%h want 0 0", Valid_D, IR_D);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (imem_addr !== 32'h3000) begin
            n_fail++;
            $display("FAIL midwait_restart: got %h want 00003000", imem_addr);
        end
        push_exp(32'h3000);
        tick();
        push_exp(32'h3004);
        tick();
        imem_ack = 1'b0;
        e = sb.pop_front();
        e = sb.pop_front();
        n_tests++;
        if ({Valid_D, IR_D, PC4_D} !== {1'b1, e.ir, e.pc4} || imem_addr !== 32'h3008) begin
            n_fail++;
            $display("FAIL midwait_seq: v=%0b ir=%h pc4=%h addr=%h want ir=%h pc4=%h 00003008", Valid_D, IR_D, PC4_D, imem_addr, e.ir, e.pc4);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jump();
        test_stall();
        test_wait_branch();
        test_reset_midwait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipeline: owns the fetch PC, drives the instruction-memory request, and loads the IF/ID pipeline register consumed by decode. It is the stage directly upstream of the decode-stage branch comparator. It consumes that comparator's `Br` result, together with jump information decoded in ID, to redirect fetch with one architectural delay slot. It absorbs instruction-memory wait states and hazard-unit stalls without losing or duplicating instructions.

## Interface
- `RESET_PC`, default `32'h0000_3000`: fetch address after reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Stall` in 1: from hazard unit; hold IF/ID and PC.
- `Br` in 1: branch-taken from decode comparator. Already 0 for non-branch instructions.
- `Imm16` in 16: branch offset field of the instruction in ID.
- `JType` in 1: instruction in ID is j/jal.
- `JTarget` in 26: jump index field of the instruction in ID.
- `JrType` in 1: instruction in ID is jr/jalr.
- `JrAddr` in 32: forwarded rs value for jr/jalr.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `imem_ack` in 1: read complete. May assert in the same cycle as `imem_req`.
- `IR_D` out 32: IF/ID instruction.
- `PC4_D` out 32: IF/ID PC+4.
- `Valid_D` out 1: IF/ID holds a real instruction (0 = bubble).

## Operation
- Registers:
  - `PC_F`
  - state ∈ {FETCH, FULL}
  - skid buffer `buf_ir`
  - `redir_pend`
  - `redir_pc`
  - `IR_D`, `PC4_D`, `Valid_D`
- Reset values: `PC_F`=`RESET_PC`, state=FETCH, `IR_D`=0, `PC4_D`=0, `Valid_D`=0, `redir_pend`=0, `redir_pc`=0. `imem_req`=0 while `rst_n` is low.
- `imem_req` = (state==FETCH). `imem_addr` = `PC_F`, held stable while `imem_req` is high.
- Redirect request (`redir`) = `Valid_D` & (`JrType` | `JType` | `Br`). Target priority is Jr > J > Br:
  - Jr: {`JrAddr`[31:2], 2'b00}.
  - J: {`PC4_D`[31:28], `JTarget`, 2'b00}.
  - Br: `PC4_D` + {{14{`Imm16`[15]}}, `Imm16`, 2'b00}, 32-bit wrap-around add.
- Delay slot:
  - The branch leaves ID on a cycle with `Stall`=0.
  - The instruction at `PC4_D` (the delay slot) always executes and is never flushed.
  - The fetch that follows the delay slot uses the redirect target.
- Next PC on IF/ID load, in priority order:
  - if the branch leaves ID this same cycle: the combinational target;
  - else if `redir_pend`: `redir_pc`;
  - else `PC_F`+4.
- `redir_pend` is cleared on that load.
- If the branch leaves ID while the delay slot has not yet been loaded: capture `redir_pc`=target and set `redir_pend`=1.
- `redir` while `Stall`=1 is ignored; the comparator re-evaluates next cycle.
- State transitions:
  - FETCH, ack, !`Stall`: IF/ID ← {`imem_rdata`, `PC_F`+4, 1}; `PC_F` ← next; stay in FETCH.
  - FETCH, ack, `Stall`: `buf_ir` ← `imem_rdata`; go to FULL; `PC_F` holds.
  - FETCH, !ack, !`Stall`: bubble; IF/ID ← {0, `PC4_D`, 0}; stay in FETCH.
  - FETCH, !ack, `Stall`: IF/ID holds.
  - FULL, `Stall`: hold everything; `imem_req`=0.
  - FULL, !`Stall`: IF/ID ← {`buf_ir`, `PC_F`+4, 1}; `PC_F` ← next; go to FETCH.
- `Stall` always freezes IF/ID, including bubbles.

## Timing
- With a zero-wait memory (`imem_ack` tied high) throughput is one instruction per cycle. An instruction fetched in cycle n appears on `IR_D` after edge n+1.
- Each memory wait cycle inserts exactly one bubble, unless `Stall` is high.
- The redirect target is the `imem_addr` on the cycle after the delay slot loads into IF/ID.
- Reset is asynchronous: every register takes its reset value immediately on `rst_n` falling, even mid-wait or in FULL. A late `imem_ack` after reset is ignored because `imem_req` is 0.
- `PC_F` wraps modulo 2^32 with no error flag.

## Test plan
- Reset, `imem_ack`=1, no stall: `imem_addr` = 0x3000, 0x3004, 0x3008 on consecutive cycles; `PC4_D` = 0x3004, 0x3008; `Valid_D`=1 from the first load.
- Taken branch at 0x3000, `Imm16`=0x0003, `Br`=1 while it is in ID: 0x3004 (delay slot) is fetched, then `imem_addr`=0x3010.
- j at 0x3000 with `JTarget`=0x0000C10: after the delay slot at 0x3004, `imem_addr`=0x0000_3040. jr with `JrAddr`=0x3043: next fetch is 0x3040.
- `imem_ack` arrives with `Stall`=1 held for 2 cycles: `imem_req` drops, state is FULL, `IR_D` is unchanged. After release the buffered word loads and the next fetch is PC+4, with no duplicate or lost instruction.
- `imem_ack` low for 3 cycles while a taken branch leaves ID: 3 bubbles appear with `Valid_D`=0. The delay slot then loads and the next `imem_addr` equals the latched target.
- `rst_n` pulsed low mid-wait: `IR_D`=0, `Valid_D`=0, `redir_pend`=0 immediately. Fetch restarts at 0x3000.
